// File: rtl/anim_playback_ctrl.sv
// Button-driven animation/speed selector with hold-to-repeat and an auto-advance playlist.
// Every output is a register; the FSM walks IDLE -> HOLD -> REPEAT while a granted button stays down.
module anim_playback_ctrl #(
  parameter int ANI_BIT     = 6,
  parameter int REPEAT_DLY  = 5_000_000,
  parameter int REPEAT_RATE = 2_000_000,
  parameter int AUTO_DWELL  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         btn_req,
  input  logic               auto_en,
  input  logic               wrap_tick,
  output logic [ANI_BIT-1:0] animation,
  output logic [3:0]         speed_step,
  output logic               step_pulse,
  output logic [1:0]         state
);

  localparam int T_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int TW    = $clog2(T_MAX);
  localparam logic [TW-1:0] DLY_LAST   = TW'(REPEAT_DLY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic [7:0]    DWELL_LAST = 8'(AUTO_DWELL - 1);

  // Action codes equal the btn_req bit index that requests them.
  localparam logic [1:0] ACT_NEXT = 2'd0;
  localparam logic [1:0] ACT_PREV = 2'd1;
  localparam logic [1:0] ACT_SLOW = 2'd2;
  localparam logic [1:0] ACT_FAST = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_t;

  state_t          fsm;
  logic [TW-1:0]   timer;
  logic [7:0]      dwell;
  logic [1:0]      grant;

  logic            act_vld;
  logic [1:0]      act_sel;
  logic [1:0]      first_bit;
  logic            held;
  logic            auto_inc;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  assign state = fsm;

  always_comb begin
    first_bit = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (btn_req[i]) first_bit = 2'(i);
    end
    held    = btn_req[grant];
    act_vld = 1'b0;
    act_sel = grant;
    case (fsm)
      IDLE: begin
        if (|btn_req) begin
          act_vld = 1'b1;
          act_sel = first_bit;
        end
      end
      HOLD:    act_vld = held && (timer == DLY_LAST);
      REPEAT:  act_vld = held && (timer == RATE_LAST);
      default: act_vld = 1'b0;
    endcase
    // A button action in the same cycle pre-empts the playlist step.
    auto_inc = (fsm == IDLE) && auto_en && wrap_tick && !act_vld && (dwell == DWELL_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      animation  <= '0;
      speed_step <= 4'd9;
      step_pulse <= 1'b0;
      fsm        <= IDLE;
      timer      <= '0;
      dwell      <= '0;
      grant      <= '0;
    end else begin
      // The pulse is registered with the new index so it sits in the cycle right after the change.
      step_pulse <= auto_inc || (act_vld && (act_sel == ACT_NEXT || act_sel == ACT_PREV));

      if (act_vld) begin
        case (act_sel)
          ACT_NEXT: animation  <= animation + 1'b1;
          ACT_PREV: animation  <= animation - 1'b1;
          ACT_SLOW: speed_step <= sat_inc(speed_step);
          ACT_FAST: speed_step <= sat_dec(speed_step);
          default:  speed_step <= speed_step;
        endcase
      end else if (auto_inc) begin
        animation <= animation + 1'b1;
      end

      case (fsm)
        IDLE: begin
          if (|btn_req) begin
            grant <= first_bit;
            timer <= '0;
            fsm   <= HOLD;
          end
        end
        HOLD: begin
          if (!held) begin
            timer <= '0;
            fsm   <= IDLE;
          end else if (timer == DLY_LAST) begin
            timer <= '0;
            fsm   <= REPEAT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!held) begin
            timer <= '0;
            fsm   <= IDLE;
          end else if (timer == RATE_LAST) begin
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer <= '0;
          fsm   <= IDLE;
        end
      endcase

      if (!auto_en || fsm != IDLE || act_vld) begin
        dwell <= '0;
      end else if (wrap_tick) begin
        dwell <= (dwell == DWELL_LAST) ? 8'd0 : dwell + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_anim_playback_ctrl.sv
// Directed bench for anim_playback_ctrl: each step queues the expected outputs, then checks them after the edge.
module tb_anim_playback_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] btn_req;
  logic       auto_en;
  logic       wrap_tick;
  logic [5:0] animation;
  logic [3:0] speed_step;
  logic       step_pulse;
  logic [1:0] state;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string tag;
    int    ani;
    int    spd;
    int    pulse;
    int    st;
  } exp_t;

  exp_t sb[$];

  anim_playback_ctrl #(
    .ANI_BIT(6),
    .REPEAT_DLY(4),
    .REPEAT_RATE(2),
    .AUTO_DWELL(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_req(btn_req),
    .auto_en(auto_en),
    .wrap_tick(wrap_tick),
    .animation(animation),
    .speed_step(speed_step),
    .step_pulse(step_pulse),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic chk_outputs(input string tag, input int ea, input int es, input int ep, input int est);
    chk({tag, ".animation"}, 32'(animation), 32'(ea));
    chk({tag, ".speed"}, 32'(speed_step), 32'(es));
    chk({tag, ".pulse"}, 32'(step_pulse), 32'(ep));
    chk({tag, ".state"}, 32'(state), 32'(est));
  endtask

  // Drive one cycle of stimulus, queue what the outputs must be after the edge, then compare.
  task automatic step(input string tag, input logic [3:0] b, input logic ae, input logic wt,
                      input int ea, input int es, input int ep, input int est);
    exp_t e;
    btn_req   = b;
    auto_en   = ae;
    wrap_tick = wt;
    sb.push_back('{tag, ea, es, ep, est});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_outputs(e.tag, e.ani, e.spd, e.pulse, e.st);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_outputs(tag, 0, 9, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    btn_req   = 4'b0000;
    auto_en   = 1'b0;
    wrap_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", 0, 9, 0, 0);
    chk("reset.dwell", 32'(dut.dwell), 32'd0);
    chk("reset.timer", 32'(dut.timer), 32'd0);
    chk("reset.grant", 32'(dut.grant), 32'd0);
    reset = 1'b0;

    // Single press of NEXT for two cycles.
    step("single.press", 4'b0001, 1'b0, 1'b0, 1, 9, 1, 1);
    step("single.hold",  4'b0001, 1'b0, 1'b0, 1, 9, 0, 1);
    step("single.rel",   4'b0000, 1'b0, 1'b0, 1, 9, 0, 0);

    // PREV held for ten cycles from animation 0.
    do_reset("reset2");
    for (int i = 1; i <= 10; i++) begin
      if (i == 1)
        step("prev.press", 4'b0010, 1'b0, 1'b0, 63, 9, 1, 1);
      else if (i < 5)
        step("prev.hold", 4'b0010, 1'b0, 1'b0, 63, 9, 0, 1);
      else
        step("prev.repeat", 4'b0010, 1'b0, 1'b0, 62 - (i - 5) / 2, 9, ((i - 5) % 2 == 0) ? 1 : 0, 2);
    end
    step("prev.rel", 4'b0000, 1'b0, 1'b0, 60, 9, 0, 0);

    // SLOWER beats FASTER; hold into saturation.
    for (int i = 1; i <= 17; i++) begin
      if (i < 5)
        step("slow.hold", 4'b1100, 1'b0, 1'b0, 60, 10, 0, 1);
      else
        step("slow.repeat", 4'b1100, 1'b0, 1'b0, 60, (11 + (i - 5) / 2 > 15) ? 15 : 11 + (i - 5) / 2, 0, 2);
    end
    step("slow.rel",   4'b1000, 1'b0, 1'b0, 60, 15, 0, 0);
    step("fast.grant", 4'b1000, 1'b0, 1'b0, 60, 14, 0, 1);
    step("fast.rel",   4'b0000, 1'b0, 1'b0, 60, 14, 0, 0);

    // Auto-advance after three wrap ticks.
    step("auto.t1",  4'b0000, 1'b1, 1'b1, 60, 14, 0, 0);
    step("auto.gap", 4'b0000, 1'b1, 1'b0, 60, 14, 0, 0);
    step("auto.t2",  4'b0000, 1'b1, 1'b1, 60, 14, 0, 0);
    step("auto.gap", 4'b0000, 1'b1, 1'b0, 60, 14, 0, 0);
    step("auto.t3",  4'b0000, 1'b1, 1'b1, 61, 14, 1, 0);
    step("auto.after", 4'b0000, 1'b1, 1'b0, 61, 14, 0, 0);

    // Button press coincident with the dwell-completing tick.
    step("coin.t1",    4'b0000, 1'b1, 1'b1, 61, 14, 0, 0);
    step("coin.t2",    4'b0000, 1'b1, 1'b1, 61, 14, 0, 0);
    step("coin.press", 4'b0001, 1'b1, 1'b1, 62, 14, 1, 1);
    chk("coin.dwell", 32'(dut.dwell), 32'd0);
    step("coin.rel",   4'b0000, 1'b1, 1'b0, 62, 14, 0, 0);
    step("coin.t1b",   4'b0000, 1'b1, 1'b1, 62, 14, 0, 0);
    step("coin.t2b",   4'b0000, 1'b1, 1'b1, 62, 14, 0, 0);
    step("coin.t3b",   4'b0000, 1'b1, 1'b1, 63, 14, 1, 0);

    // Reset asserted mid-REPEAT at animation 5, released with NEXT still held.
    do_reset("reset3");
    for (int i = 1; i <= 11; i++) begin
      if (i == 1)
        step("next.press", 4'b0001, 1'b0, 1'b0, 1, 9, 1, 1);
      else if (i < 5)
        step("next.hold", 4'b0001, 1'b0, 1'b0, 1, 9, 0, 1);
      else
        step("next.repeat", 4'b0001, 1'b0, 1'b0, 2 + (i - 5) / 2, 9, ((i - 5) % 2 == 0) ? 1 : 0, 2);
    end
    #2;
    reset = 1'b1;
    #1;
    chk_outputs("midrst", 0, 9, 0, 0);
    chk("midrst.timer", 32'(dut.timer), 32'd0);
    chk("midrst.grant", 32'(dut.grant), 32'd0);
    @(posedge clk);
    #1;
    chk_outputs("midrst.held", 0, 9, 0, 0);
    #2;
    reset = 1'b0;
    step("midrst.new", 4'b0001, 1'b0, 1'b0, 1, 9, 1, 1);
    step("midrst.rel", 4'b0000, 1'b0, 1'b0, 1, 9, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
